// File: rtl/arb_mux_2to1_pkg.sv
// Shared definitions for the two-source arbitrating output mux.
// Optional feature: ARB_MUX_ROUND_ROBIN_EN selects round-robin arbitration (default: fixed priority).
package arb_mux_2to1_pkg;

    localparam int unsigned DEFAULT_WIDTH = 64;

    localparam int unsigned SRC0 = 0;
    localparam int unsigned SRC1 = 1;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

endpackage : arb_mux_2to1_pkg

// File: rtl/arb_mux_2to1_grant.sv
// Combinational two-request arbiter; ptr selects the preferred source when both request.
// Optional feature: ARB_MUX_ROUND_ROBIN_EN drives ptr from a rotating pointer in the top.
module arb_2_grant (
    input  logic req0,
    input  logic req1,
    input  logic ptr,
    output logic gnt0,
    output logic gnt1
);

    // Source 0 wins unless source 1 also requests and is the preferred one.
    always_comb begin
        gnt0 = req0 & (~req1 | ~ptr);
        gnt1 = req1 & ~gnt0;
    end

endmodule : arb_2_grant

// File: rtl/arb_mux_2to1.sv
// Two-source valid/ready merge into a single registered output stage.
// Optional feature: define ARB_MUX_ROUND_ROBIN_EN for round-robin grant on contention;
// undefined builds use fixed priority to source 0 with no pointer state.
module arb_mux_2to1
    import arb_mux_2to1_pkg::*;
#(
    parameter int unsigned width = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [width-1:0] i0,
    input  logic             i0_valid,
    output logic             i0_ready,
    input  logic [width-1:0] i1,
    input  logic             i1_valid,
    output logic             i1_ready,
    output logic [width-1:0] o,
    output logic             o_sel,
    output logic             o_valid,
    input  logic             o_ready
);

    state_e             state_q, state_d;
    logic [width-1:0]   o_q, o_d;
    logic               o_sel_q, o_sel_d;
    logic               load;
    logic               accept;
    logic               gnt0, gnt1;
    logic               arb_ptr;

`ifdef ARB_MUX_ROUND_ROBIN_EN
    logic               ptr_q, ptr_d;

    // Next preferred source is the one not granted on the latest accepted input.
    always_comb begin
        ptr_d = ptr_q;
        if (accept) begin
            ptr_d = gnt0;
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign arb_ptr = ptr_q;
`else
    assign arb_ptr = 1'b0;
`endif

    arb_2_grant u_grant (
        .req0 (i0_valid),
        .req1 (i1_valid),
        .ptr  (arb_ptr),
        .gnt0 (gnt0),
        .gnt1 (gnt1)
    );

    // Next-state, datapath load and input handshake.
    always_comb begin
        state_d  = state_q;
        o_d      = o_q;
        o_sel_d  = o_sel_q;
        load     = (state_q == EMPTY) | o_ready;
        accept   = ~rst & load & (i0_valid | i1_valid);
        i0_ready = ~rst & load & gnt0;
        i1_ready = ~rst & load & gnt1;

        if (accept) begin
            state_d = FULL;
            o_d     = gnt1 ? i1 : i0;
            o_sel_d = gnt1 ? 1'(SRC1) : 1'(SRC0);
        end else if ((state_q == FULL) && o_ready) begin
            state_d = EMPTY;
        end
    end

    // State and output registers; reset drops any held word.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            o_q     <= '0;
            o_sel_q <= 1'b0;
        end else begin
            state_q <= state_d;
            o_q     <= o_d;
            o_sel_q <= o_sel_d;
        end
    end

    assign o       = o_q;
    assign o_sel   = o_sel_q;
    assign o_valid = (state_q == FULL);

endmodule : arb_mux_2to1

// File: tb/tb_arb_mux_2to1.sv
// Self-checking bench for arb_mux_2to1; honours ARB_MUX_ROUND_ROBIN_EN in its reference model.
module tb_arb_mux_2to1;

    localparam int unsigned W = 64;

    typedef struct {
        logic [W-1:0] d;
        logic         s;
    } word_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] i0, i1, o;
    logic         i0_valid, i1_valid, i0_ready, i1_ready;
    logic         o_sel, o_valid, o_ready;

    int n_tests = 0;
    int n_fail  = 0;

    word_t        sb_q[$];
    logic         sel_log[$];
    int           xfer_cyc[$];
    logic         m_full, m_pref, m_init, m_last_sel;
    logic [W-1:0] m_last;
    logic         m_acc0, m_acc1;
    int           cyc = 0;

    always #5 clk = ~clk;

    arb_mux_2to1 #(.width(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .i0       (i0),
        .i0_valid (i0_valid),
        .i0_ready (i0_ready),
        .i1       (i1),
        .i1_valid (i1_valid),
        .i1_ready (i1_ready),
        .o        (o),
        .o_sel    (o_sel),
        .o_valid  (o_valid),
        .o_ready  (o_ready)
    );

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, obs, exp);
        end
    endtask

    // One clock: check handshake/outputs against the model, then advance the model at the edge.
    task automatic tick();
        logic  load, g0, g1, e0r, e1r, xfer;
        word_t w;
        #1;
        load = ~m_full | o_ready;
        g0   = i0_valid & (~i1_valid | ~m_pref);
        g1   = i1_valid & ~g0;
        e0r  = ~rst & load & g0;
        e1r  = ~rst & load & g1;
        xfer = ~rst & m_full & o_ready;
        check("i0_ready", W'(i0_ready), W'(e0r));
        check("i1_ready", W'(i1_ready), W'(e1r));
        if (m_init) begin
            check("o_valid", W'(o_valid), W'(m_full));
            if (m_full) begin
                if (sb_q.size() == 0) begin
                    check("sb_nonempty", W'(0), W'(1));
                end else begin
                    check("o_data", o, sb_q[0].d);
                    check("o_sel", W'(o_sel), W'(sb_q[0].s));
                end
            end else begin
                check("o_hold", o, m_last);
                check("o_sel_hold", W'(o_sel), W'(m_last_sel));
            end
        end
        m_acc0 = e0r;
        m_acc1 = e1r;
        w.d = e1r ? i1 : i0;
        w.s = e1r;
        @(posedge clk);
        if (rst) begin
            m_full = 1'b0; m_pref = 1'b0; m_last = '0; m_last_sel = 1'b0;
            sb_q.delete();
        end else begin
            if (xfer && sb_q.size() > 0) begin
                sel_log.push_back(sb_q[0].s);
                xfer_cyc.push_back(cyc);
                void'(sb_q.pop_front());
            end
            if (e0r | e1r) begin
                sb_q.push_back(w);
                m_full = 1'b1;
                m_last = w.d;
                m_last_sel = w.s;
`ifdef ARB_MUX_ROUND_ROBIN_EN
                m_pref = e0r;
`endif
            end else if (m_full && o_ready) begin
                m_full = 1'b0;
            end
        end
        m_init = 1'b1;
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        logic [3:0] exp_sel;
        logic [W-1:0] d_a, d_b, d_c, d_d;
        d_a = {4'hA, 60'h0};
        d_b = {4'hB, 60'h0};
        d_c = {4'hC, 60'h0};
        d_d = {4'hD, 60'h0};
        m_full = 1'b0; m_pref = 1'b0; m_init = 1'b0; m_last = '0; m_last_sel = 1'b0;
        rst = 1'b1; o_ready = 1'b1;
        i0 = d_a; i1 = d_b; i0_valid = 1'b1; i1_valid = 1'b1;
        @(negedge clk);

        // Reset for two cycles with both sources requesting.
        tick(); tick();
        check("rst_o", o, '0);

        // First word straight after reset.
        rst = 1'b0; i1_valid = 1'b0;
        tick();
        i0_valid = 1'b0;

        // Backpressure holds the word for three cycles, then B loads.
        o_ready = 1'b0; i1 = d_b; i1_valid = 1'b1;
        repeat (3) tick();
        o_ready = 1'b1;
        tick();
        i1_valid = 1'b0;
        tick();
        tick();

        // Contention: both valid continuously.
        sel_log.delete();
        i0 = d_a; i1 = d_c; i0_valid = 1'b1; i1_valid = 1'b1;
        repeat (5) tick();
        i0_valid = 1'b0; i1_valid = 1'b0;
        tick();
`ifdef ARB_MUX_ROUND_ROBIN_EN
        exp_sel = 4'b1010;
`else
        exp_sel = 4'b0000;
`endif
        check("contend_cnt", W'(sel_log.size()), W'(5));
        for (int k = 0; k < 4 && k < sel_log.size(); k++)
            check("contend_sel", W'(sel_log[k]), W'(exp_sel[k]));

        // Single word then idle: o_valid drops and o retains D.
        i1 = d_d; i1_valid = 1'b1;
        tick();
        i1_valid = 1'b0;
        repeat (3) tick();
        check("retain_d", o, d_d);

        // Reset while FULL holding C.
        i0 = d_c; i0_valid = 1'b1;
        tick();
        i0_valid = 1'b0; o_ready = 1'b0; rst = 1'b1;
        i1_valid = 1'b1;
        tick();
        rst = 1'b0; i1_valid = 1'b0; o_ready = 1'b1;
        check("rst_full_o", o, '0);
        check("rst_full_vld", W'(o_valid), W'(0));
        tick();

        // Back-to-back stream of 8 alternating-source words.
        xfer_cyc.delete();
        for (int k = 0; k < 8; k++) begin
            i0_valid = (k % 2 == 0);
            i1_valid = (k % 2 == 1);
            i0 = {$urandom, $urandom};
            i1 = {$urandom, $urandom};
            tick();
        end
        i0_valid = 1'b0; i1_valid = 1'b0;
        tick();
        check("stream_cnt", W'(xfer_cyc.size()), W'(8));
        if (xfer_cyc.size() == 8)
            check("stream_span", W'(xfer_cyc[7] - xfer_cyc[0]), W'(7));

        // Random traffic; a waiting source keeps its data until accepted.
        for (int k = 0; k < 300; k++) begin
            if (!i0_valid || m_acc0) begin
                i0_valid = ($urandom_range(0, 2) != 0);
                i0 = {$urandom, $urandom};
            end
            if (!i1_valid || m_acc1) begin
                i1_valid = ($urandom_range(0, 2) != 0);
                i1 = {$urandom, $urandom};
            end
            o_ready = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 63) == 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_arb_mux_2to1
